regs_wport_sched: RTL and testbench
===================================

Name: regs_wport_sched

Overview:
- Schedules the register file's single write port between two requesters.
  - Requester A: in-order pipeline writeback.
  - Requester B: long-latency unit results (multiply/divide, load completion).
- Keeps a 32-entry pending-write scoreboard and flags RAW/WAW hazards to decode.
- Sits between the WB stage / long-latency unit and the register file write inputs (we, waddr, wdata).

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- FIFO_DEPTH, 2, B-side result buffer entries (power of 2, >=2)
- STARVE_LIMIT, 4, cycles a buffered B result may wait before A is forced to hold

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-high (1 = reset asserted)
- a_valid  in  1  writeback request
- a_waddr  in  ADDR_W  writeback destination
- a_wdata  in  DATA_W  writeback data
- a_ready  out  1  writeback accepted this cycle
- b_valid  in  1  long-latency result valid
- b_waddr  in  ADDR_W  result destination
- b_wdata  in  DATA_W  result data
- b_ready  out  1  FIFO not full
- iss_valid  in  1  long-latency op issued
- iss_waddr  in  ADDR_W  its destination
- chk_re1  in  1  decode read-port-1 enable
- chk_raddr1  in  ADDR_W  decode read-port-1 address
- chk_re2  in  1  decode read-port-2 enable
- chk_raddr2  in  ADDR_W  decode read-port-2 address
- chk_we  in  1  decode destination write enable
- chk_waddr  in  ADDR_W  decode destination address
- hazard_stall  out  1  decode must stall
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty; scoreboard all 0; age=0; FSM=ARB_A.
  - Outputs a_ready=1, b_ready=1, hazard_stall=0 while in reset.
  - Reset mid-operation discards buffered B results and pending bits.
- FSM states:
  - ARB_A:
    - a_ready=1.
    - Grant A if a_valid.
    - Otherwise pop the FIFO head if non-empty.
    - Go to ARB_FORCE when age reaches STARVE_LIMIT and the FIFO is still non-empty and not popped this cycle.
  - ARB_FORCE:
    - a_ready=0; A must hold its request.
    - Pop the FIFO head unconditionally (the FIFO is non-empty by construction).
    - Age returns to 0; next state ARB_A.
- Age counter:
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on every pop and whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output latency:
  - A grant or FIFO pop in cycle N gives rf_we/rf_waddr/rf_wdata in cycle N+1.
  - rf_we=0 in cycles with no grant.
  - Read-during-write in cycle N+1 is covered by register file bypass.
- Register 0:
  - A request or popped entry with waddr==0 is accepted/popped but drives rf_we=0 next cycle.
  - iss_valid with iss_waddr==0 sets no pending bit.
- FIFO:
  - b_ready = !full; push when b_valid & b_ready.
  - No same-cycle bypass: a pushed entry is first eligible for pop the following cycle.
  - Push and pop in the same cycle are allowed when not full.
  - Push pointer wraps modulo FIFO_DEPTH.
- Scoreboard:
  - Bit[iss_waddr] sets on iss_valid.
  - Bit[waddr] clears at the edge that registers rf_we=1 for a popped B entry.
  - Same-cycle set and clear on the same register: set wins.
  - A-side writes never touch the scoreboard.
- hazard_stall is combinational and asserts if any of the following hold:
  - chk_re1 and pend[chk_raddr1]
  - chk_re2 and pend[chk_raddr2]
  - chk_we and pend[chk_waddr]
  - Address 0 never hazards.
- Duplicate issue to a register that is already pending cannot occur because of the WAW stall; the scoreboard tracks one outstanding op per register.

Decomposition:
- Shared package/macro file additions:
  - ArbA / ArbForce state encodings.
  - SbBus (32-bit scoreboard) width define.
  - Reuse the existing RegAddrBus, RegBus, ZeroWord and RegNumLog2 defines.
- Sub-module: regs_wb_fifo (parameterised sync FIFO with push/pop/full/empty, head data).
- Arbitration FSM, age counter and scoreboard stay in the top module.

Test Plan:
- Reset mid-stream:
  - Stimulus: FIFO holds 2 entries and pend[5]=1; assert rst_n=1 asynchronously.
  - Response: rf_we=0 and hazard_stall=0 immediately; after release b_ready=1 and no stale writes appear.
- A only:
  - Stimulus: a_valid with a_waddr=3, a_wdata=0xDEADBEEF in cycle N.
  - Response: a_ready=1 in N; rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF in N+1.
- Scoreboard RAW:
  - Stimulus: iss_valid to reg 7; next cycle chk_re1=1, chk_raddr1=7; B returns reg 7 = 0x55 while A is idle.
  - Response:
    - hazard_stall=1 until the cycle rf_we=1, rf_waddr=7.
    - hazard_stall=0 in that same cycle.
- Starvation:
  - Stimulus: a_valid held high continuously; push a B result for reg 9 = 0x1234; STARVE_LIMIT=4.
  - Response:
    - After 4 waiting cycles, one cycle has a_ready=0.
    - The following cycle has rf_waddr=9, rf_wdata=0x1234.
    - A resumes with its data unchanged.
- FIFO full:
  - Stimulus: with A continuously busy, push 2 B results.
  - Response:
    - b_ready=0 and a third b_valid is not accepted.
    - After one pop, b_ready=1.
    - Entries are written in push order.
- Register 0:
  - Stimulus: a_waddr=0 with a_valid=1; iss_valid with iss_waddr=0; chk_raddr1=0.
  - Response: a_ready=1, rf_we=0 next cycle, no pending bit set, hazard_stall=0.

Source files
------------

// File: rtl/regs_wport_sched_pkg.sv
// Shared definitions for the register-file write-port scheduler.
// Contents: register address/data widths, scoreboard width, zero word,
// and the arbitration state encoding.
package regs_wport_sched_pkg;

   localparam int REG_NUM_LOG2 = 5;
   localparam int REG_DATA_W   = 32;
   localparam int SB_W         = 1 << REG_NUM_LOG2;

   typedef logic [REG_NUM_LOG2-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0]   reg_bus_t;
   typedef logic [SB_W-1:0]         sb_bus_t;

   localparam reg_bus_t ZERO_WORD = '0;

   typedef enum logic {
      ARB_A     = 1'b0,
      ARB_FORCE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/regs_wb_fifo.sv
// Small synchronous FIFO buffering long-latency results until the
// write port is free. Head entry is visible on o_rdata while not empty;
// a pushed entry is only visible from the following cycle.
// Ports:
//   clk, rst_n        clock; asynchronous reset, active-high despite the name
//   i_push, i_wdata   write side (ignored while full)
//   i_pop             drop head entry (ignored while empty)
//   o_rdata           head entry
//   o_full, o_empty   occupancy flags
module regs_wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]   r_mem [DEPTH];
   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   logic           w_do_push;
   logic           w_do_pop;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_mem    <= '{default: '0};
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
            r_wr_ptr                   <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/regs_wport_sched.sv
// Register-file write-port scheduler. Arbitrates the single write port
// between in-order writeback (A) and buffered long-latency results (B),
// keeps a per-register pending bit for issued long-latency ops and flags
// RAW/WAW hazards back to decode.
// Ports:
//   clk, rst_n                    clock; asynchronous reset, active-high
//   a_valid/a_waddr/a_wdata/a_ready   writeback request
//   b_valid/b_waddr/b_wdata/b_ready   long-latency result push
//   iss_valid/iss_waddr           long-latency issue (sets pending bit)
//   chk_*                         decode operands checked against pending
//   hazard_stall                  combinational stall to decode
//   rf_we/rf_waddr/rf_wdata       registered register-file write
//
// state     | meaning
// ARB_A     | A has priority; B head drains on idle A cycles
// ARB_FORCE | B head starved too long; A held off for one cycle
module regs_wport_sched
   import regs_wport_sched_pkg::*;
#(
   parameter int ADDR_W       = REG_NUM_LOG2,
   parameter int DATA_W       = REG_DATA_W,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_waddr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_waddr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ready,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_waddr,
   input  logic              chk_re1,
   input  logic [ADDR_W-1:0] chk_raddr1,
   input  logic              chk_re2,
   input  logic [ADDR_W-1:0] chk_raddr2,
   input  logic              chk_we,
   input  logic [ADDR_W-1:0] chk_waddr,
   output logic              hazard_stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int PEND_W = 1 << ADDR_W;
   localparam int AGE_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);
   localparam int ENT_W  = ADDR_W + DATA_W;

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [AGE_W-1:0]   r_age;
   logic [AGE_W-1:0]   w_age_nxt;
   logic [PEND_W-1:0]  r_pend;
   logic [PEND_W-1:0]  w_pend_set;
   logic [PEND_W-1:0]  w_pend_clr;
   logic               w_grant_a;
   logic               w_pop;
   logic               w_push;
   logic               w_full;
   logic               w_empty;
   logic [ENT_W-1:0]   w_head;
   logic [ADDR_W-1:0]  w_head_addr;
   logic [DATA_W-1:0]  w_head_data;

   assign b_ready = !w_full;
   assign w_push  = b_valid && !w_full;
   assign {w_head_addr, w_head_data} = w_head;

   regs_wb_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata ({b_waddr, b_wdata}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      a_ready     = 1'b1;
      w_grant_a   = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         ARB_A: begin
            w_grant_a = a_valid;
            w_pop     = !a_valid && !w_empty;
         end
         ARB_FORCE: begin
            a_ready     = 1'b0;
            w_pop       = !w_empty;
            w_state_nxt = ARB_A;
         end
         default: w_state_nxt = ARB_A;
      endcase

      if (w_pop || w_empty) begin
         w_age_nxt = '0;
      end else if (r_age != AGE_MAX) begin
         w_age_nxt = r_age + AGE_W'(1);
      end else begin
         w_age_nxt = r_age;
      end

      // Force on the same edge the age counter hits the limit, so A is
      // held off right after the last allowed waiting cycle.
      if (r_state == ARB_A && !w_pop && !w_empty && w_age_nxt == AGE_MAX) begin
         w_state_nxt = ARB_FORCE;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= ARB_A;
         r_age   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_age   <= w_age_nxt;
      end
   end

   // Set is applied after clear so a same-cycle issue to the register
   // being retired keeps its pending bit.
   always_comb begin
      w_pend_set = '0;
      w_pend_clr = '0;
      if (iss_valid && iss_waddr != '0) begin
         w_pend_set[iss_waddr] = 1'b1;
      end
      if (w_pop && w_head_addr != '0) begin
         w_pend_clr[w_head_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
      end
   end

   assign hazard_stall = (chk_re1 && chk_raddr1 != '0 && r_pend[chk_raddr1]) ||
                         (chk_re2 && chk_raddr2 != '0 && r_pend[chk_raddr2]) ||
                         (chk_we  && chk_waddr  != '0 && r_pend[chk_waddr]);

   // Writes to register 0 still consume the slot but never assert rf_we.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= DATA_W'(ZERO_WORD);
      end else begin
         rf_we <= 1'b0;
         if (w_grant_a) begin
            rf_we    <= (a_waddr != '0);
            rf_waddr <= a_waddr;
            rf_wdata <= a_wdata;
         end else if (w_pop) begin
            rf_we    <= (w_head_addr != '0);
            rf_waddr <= w_head_addr;
            rf_wdata <= w_head_data;
         end
      end
   end

endmodule

// File: tb/tb_regs_wport_sched.sv
module tb_regs_wport_sched;

   logic        clk;
   logic        rst_n;
   logic        a_valid;
   logic [4:0]  a_waddr;
   logic [31:0] a_wdata;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_waddr;
   logic [31:0] b_wdata;
   logic        b_ready;
   logic        iss_valid;
   logic [4:0]  iss_waddr;
   logic        chk_re1;
   logic [4:0]  chk_raddr1;
   logic        chk_re2;
   logic [4:0]  chk_raddr2;
   logic        chk_we;
   logic [4:0]  chk_waddr;
   logic        hazard_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   regs_wport_sched #(
      .ADDR_W       (5),
      .DATA_W       (32),
      .FIFO_DEPTH   (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_valid      (a_valid),
      .a_waddr      (a_waddr),
      .a_wdata      (a_wdata),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_waddr      (b_waddr),
      .b_wdata      (b_wdata),
      .b_ready      (b_ready),
      .iss_valid    (iss_valid),
      .iss_waddr    (iss_waddr),
      .chk_re1      (chk_re1),
      .chk_raddr1   (chk_raddr1),
      .chk_re2      (chk_re2),
      .chk_raddr2   (chk_raddr2),
      .chk_we       (chk_we),
      .chk_waddr    (chk_waddr),
      .hazard_stall (hazard_stall),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_wr(input logic [4:0] addr, input logic [31:0] data);
      wr_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Every register-file write is matched against the expected queue.
   always @(negedge clk) begin
      wr_t e;
      if (rst_n === 1'b0 && rf_we !== 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {31'd0, rf_we}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
            chk("wr_data", rf_wdata, e.data);
         end
      end
   end

   initial begin
      rst_n      = 1'b1;
      a_valid    = 1'b0;
      a_waddr    = '0;
      a_wdata    = '0;
      b_valid    = 1'b0;
      b_waddr    = '0;
      b_wdata    = '0;
      iss_valid  = 1'b0;
      iss_waddr  = '0;
      chk_re1    = 1'b0;
      chk_raddr1 = '0;
      chk_re2    = 1'b0;
      chk_raddr2 = '0;
      chk_we     = 1'b0;
      chk_waddr  = '0;

      // Reset state
      #2;
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
      chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
      #20;
      rst_n = 1'b0;
      cyc();

      // A only
      a_valid = 1'b1;
      a_waddr = 5'd3;
      a_wdata = 32'hDEADBEEF;
      exp_wr(5'd3, 32'hDEADBEEF);
      #1;
      chk("a_only_ready", {31'd0, a_ready}, 32'd1);
      cyc();
      a_valid = 1'b0;
      chk("a_only_we", {31'd0, rf_we}, 32'd1);
      chk("a_only_waddr", {27'd0, rf_waddr}, 32'd3);
      cyc();
      chk("a_only_we_drop", {31'd0, rf_we}, 32'd0);

      // Register 0
      a_valid    = 1'b1;
      a_waddr    = 5'd0;
      a_wdata    = 32'h11111111;
      iss_valid  = 1'b1;
      iss_waddr  = 5'd0;
      chk_re1    = 1'b1;
      chk_raddr1 = 5'd0;
      #1;
      chk("r0_a_ready", {31'd0, a_ready}, 32'd1);
      chk("r0_hazard_now", {31'd0, hazard_stall}, 32'd0);
      cyc();
      a_valid   = 1'b0;
      iss_valid = 1'b0;
      #1;
      chk("r0_rf_we", {31'd0, rf_we}, 32'd0);
      chk("r0_hazard_after", {31'd0, hazard_stall}, 32'd0);
      chk_re1 = 1'b0;
      cyc();

      // Scoreboard RAW / WAW
      iss_valid = 1'b1;
      iss_waddr = 5'd7;
      cyc();
      iss_valid  = 1'b0;
      chk_re1    = 1'b1;
      chk_raddr1 = 5'd7;
      #1;
      chk("raw_re1", {31'd0, hazard_stall}, 32'd1);
      chk_re1    = 1'b0;
      chk_re2    = 1'b1;
      chk_raddr2 = 5'd7;
      #1;
      chk("raw_re2", {31'd0, hazard_stall}, 32'd1);
      chk_re2   = 1'b0;
      chk_we    = 1'b1;
      chk_waddr = 5'd7;
      #1;
      chk("waw_we", {31'd0, hazard_stall}, 32'd1);
      chk_waddr = 5'd6;
      #1;
      chk("no_haz_other", {31'd0, hazard_stall}, 32'd0);
      chk_we  = 1'b0;
      chk_re1 = 1'b1;
      b_valid = 1'b1;
      b_waddr = 5'd7;
      b_wdata = 32'h55;
      exp_wr(5'd7, 32'h55);
      #1;
      chk("raw_push_ready", {31'd0, b_ready}, 32'd1);
      chk("raw_push_haz", {31'd0, hazard_stall}, 32'd1);
      cyc();
      b_valid = 1'b0;
      #1;
      chk("raw_pop_haz", {31'd0, hazard_stall}, 32'd1);
      cyc();
      chk("raw_wr_we", {31'd0, rf_we}, 32'd1);
      chk("raw_wr_addr", {27'd0, rf_waddr}, 32'd7);
      chk("raw_wr_haz", {31'd0, hazard_stall}, 32'd0);
      chk_re1 = 1'b0;
      cyc();

      // Starvation: A busy throughout, one B result
      a_valid = 1'b1;
      a_waddr = 5'd2;
      a_wdata = 32'hA0A0A0A0;
      b_waddr = 5'd9;
      b_wdata = 32'h1234;
      for (int k = 0; k < 7; k++) begin
         b_valid = (k == 0);
         #1;
         if (k == 5) begin
            chk("starve_a_ready_low", {31'd0, a_ready}, 32'd0);
            exp_wr(5'd9, 32'h1234);
         end else begin
            chk("starve_a_ready_high", {31'd0, a_ready}, 32'd1);
            exp_wr(5'd2, 32'hA0A0A0A0);
         end
         cyc();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      cyc();

      // FIFO full: A busy, three B attempts, third refused
      a_valid = 1'b1;
      a_waddr = 5'd4;
      a_wdata = 32'h44;
      for (int k = 0; k < 11; k++) begin
         logic exp_ar;
         logic exp_br;
         b_valid = (k <= 2);
         b_waddr = 5'(10 + k);
         b_wdata = 32'hB0 + 32'(k);
         exp_ar  = !(k == 5 || k == 10);
         exp_br  = (k <= 1) || (k >= 6);
         #1;
         chk("full_a_ready", {31'd0, a_ready}, {31'd0, exp_ar});
         chk("full_b_ready", {31'd0, b_ready}, {31'd0, exp_br});
         if (exp_ar) exp_wr(5'd4, 32'h44);
         else if (k == 5) exp_wr(5'd10, 32'hB0);
         else exp_wr(5'd11, 32'hB1);
         cyc();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      repeat (3) cyc();

      // Reset mid-stream: FIFO full, pend[5] set
      a_valid = 1'b1;
      a_waddr = 5'd6;
      a_wdata = 32'h66;
      for (int k = 0; k < 2; k++) begin
         b_valid   = 1'b1;
         b_waddr   = 5'(20 + k);
         b_wdata   = 32'hC0 + 32'(k);
         iss_valid = (k == 0);
         iss_waddr = 5'd5;
         exp_wr(5'd6, 32'h66);
         cyc();
      end
      b_valid    = 1'b0;
      iss_valid  = 1'b0;
      chk_re1    = 1'b1;
      chk_raddr1 = 5'd5;
      #1;
      chk("mid_pre_haz", {31'd0, hazard_stall}, 32'd1);
      chk("mid_pre_full", {31'd0, b_ready}, 32'd0);
      #5;
      rst_n   = 1'b1;
      a_valid = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
      chk("mid_rst_haz", {31'd0, hazard_stall}, 32'd0);
      chk("mid_rst_a_ready", {31'd0, a_ready}, 32'd1);
      chk("mid_rst_b_ready", {31'd0, b_ready}, 32'd1);
      #10;
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("post_rst_b_ready", {31'd0, b_ready}, 32'd1);
         chk("post_rst_haz", {31'd0, hazard_stall}, 32'd0);
         chk("post_rst_we", {31'd0, rf_we}, 32'd0);
      end
      chk_re1 = 1'b0;
      repeat (2) cyc();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
